// File: rtl/tone_phase_accumulator.sv
// NCO phase stage: divides the system clock down to the audio sample rate, takes tuning
// words over valid/ready and advances a wrapping phase accumulator for the sine LUT.
module tone_phase_accumulator #(
   parameter int unsigned SAMPLE_DIV  = 520,
   parameter int unsigned ACC_W       = 24,
   parameter int unsigned GLIDE_SHIFT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [ACC_W-1:0] tuning_word,
   input  logic             tw_valid,
   output logic             tw_ready,
   input  logic             note_on,
   input  logic             note_off,
   input  logic             glide_en,
   output logic [ACC_W-1:0] accumulator,
   output logic             sample_tick,
   output logic             active
);

   localparam int unsigned      CNT_W   = $clog2(SAMPLE_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

   typedef enum logic {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              sample_tick_q;
   logic              active_q;
   logic [ACC_W-1:0]  acc_q;
   logic [ACC_W-1:0]  cur_tw_q;
   logic [ACC_W-1:0]  tgt_tw_q;
   logic [ACC_W-1:0]  pend_w_q;
   logic              pend_v_q;
   logic              start_q;
   logic              stop_q;

   logic              tick;
   logic              capture;
   logic [ACC_W-1:0]  new_tgt;
   logic signed [ACC_W:0] diff;
   logic signed [ACC_W:0] step;
   logic [ACC_W-1:0]  cur_tw_d;

   assign tick    = (cnt_q == CNT_MAX);
   assign capture = tw_valid & ~pend_v_q;
   // A word still waiting in the pending register becomes the target on this very tick.
   assign new_tgt = pend_v_q ? pend_w_q : tgt_tw_q;

   // Next increment while playing: jump straight to the target, or close a fixed
   // fraction of the remaining distance and snap once that fraction rounds to zero.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      cur_tw_d = new_tgt;
      diff     = $signed({1'b0, new_tgt}) - $signed({1'b0, cur_tw_q});
      step     = diff >>> GLIDE_SHIFT;
      if (glide_en && (step != '0)) begin
         cur_tw_d = cur_tw_q + step[ACC_W-1:0];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         sample_tick_q <= 1'b0;
         active_q      <= 1'b0;
         acc_q         <= '0;
         cur_tw_q      <= '0;
         tgt_tw_q      <= '0;
         pend_w_q      <= '0;
         pend_v_q      <= 1'b0;
         start_q       <= 1'b0;
         stop_q        <= 1'b0;
      end else begin
         cnt_q         <= tick ? '0 : cnt_q + CNT_W'(1);
         sample_tick_q <= tick;

         // Capture needs an empty pending slot, so it never collides with consumption.
         if (tick && pend_v_q) begin
            tgt_tw_q <= pend_w_q;
            pend_v_q <= 1'b0;
         end
         if (capture) begin
            pend_w_q <= tuning_word;
            pend_v_q <= 1'b1;
         end

         // A pulse landing on the tick cycle itself is kept for the following tick.
         if (tick) begin
            start_q <= note_on;
            stop_q  <= note_off;
         end else begin
            start_q <= start_q | note_on;
            stop_q  <= stop_q | note_off;
         end

         if (tick) begin
            unique case (state_q)
               IDLE: begin
                  if (start_q) begin
                     state_q  <= PLAY;
                     active_q <= 1'b1;
                     acc_q    <= '0;
                     cur_tw_q <= new_tgt;
                  end
               end
               PLAY: begin
                  if (start_q) begin
                     acc_q    <= '0;
                     cur_tw_q <= new_tgt;
                  end else if (stop_q) begin
                     state_q  <= IDLE;
                     active_q <= 1'b0;
                     acc_q    <= '0;
                  end else begin
                     acc_q    <= acc_q + cur_tw_q;
                     cur_tw_q <= cur_tw_d;
                  end
               end
            endcase
         end
      end
   end

   assign tw_ready    = ~pend_v_q;
   assign accumulator = acc_q;
   assign sample_tick = sample_tick_q;
   assign active      = active_q;

endmodule

// File: tb/tb_tone_phase_accumulator.sv
// Scoreboard bench for tone_phase_accumulator: a per-sample reference model queues the
// expected phase/state for each tick, and a monitor compares whenever sample_tick fires.
module tb_tone_phase_accumulator;

   localparam int unsigned SD = 4;
   localparam int unsigned AW = 24;
   localparam int unsigned GS = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] tuning_word;
   logic          tw_valid;
   logic          tw_ready;
   logic          note_on;
   logic          note_off;
   logic          glide_en;
   logic [AW-1:0] accumulator;
   logic          sample_tick;
   logic          active;

   tone_phase_accumulator #(
      .SAMPLE_DIV (SD),
      .ACC_W      (AW),
      .GLIDE_SHIFT(GS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tuning_word(tuning_word),
      .tw_valid   (tw_valid),
      .tw_ready   (tw_ready),
      .note_on    (note_on),
      .note_off   (note_off),
      .glide_en   (glide_en),
      .accumulator(accumulator),
      .sample_tick(sample_tick),
      .active     (active)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned   stamp;
      logic [AW-1:0] acc;
      logic          act;
      logic          rdy;
      bit            is_rst;
   } exp_t;

   exp_t          exp_q[$];
   logic [AW-1:0] src_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one call per clock edge, described per audio sample.
   int unsigned   m_edge;
   logic [AW-1:0] m_phase, m_word, m_target;
   logic [AW-1:0] m_pend[$];
   bit            m_start, m_stop, m_play, have_reset = 0;

   function automatic logic [AW-1:0] glide_next(input logic [AW-1:0] cur, input logic [AW-1:0] tgt);
      int diff, stp;
      diff = int'(tgt) - int'(cur);
      if (diff >= 0) stp = diff / (1 << GS);
      else           stp = -((-diff + (1 << GS) - 1) / (1 << GS));
      if (stp == 0) return tgt;
      return AW'(int'(cur) + stp);
   endfunction

   task automatic model_edge(output bit accepted);
      exp_t          e;
      bit            rdy, tk;
      logic [AW-1:0] t;
      accepted = 0;
      if (reset) begin
         m_edge = 0; m_phase = '0; m_word = '0; m_target = '0;
         m_pend.delete(); m_start = 0; m_stop = 0; m_play = 0; have_reset = 1;
         e = '{stamp: cyc + 1, acc: '0, act: 1'b0, rdy: 1'b1, is_rst: 1'b1};
         exp_q.push_back(e);
         return;
      end
      rdy = (m_pend.size() == 0);
      accepted = tw_valid && rdy;
      m_edge++;
      tk = (m_edge % SD == 0);
      if (tk) begin
         t = m_target;
         if (m_pend.size() != 0) t = m_pend.pop_front();
         m_target = t;
         if (m_start) begin
            m_phase = '0; m_word = t; m_play = 1;
         end else if (m_stop) begin
            m_phase = '0; m_play = 0;
         end else if (m_play) begin
            m_phase = AW'((longint'(m_phase) + longint'(m_word)) % (longint'(1) << AW));
            m_word  = glide_en ? glide_next(m_word, t) : t;
         end
         m_start = 0; m_stop = 0;
      end
      if (note_on)  m_start = 1;
      if (note_off) m_stop  = 1;
      if (accepted) m_pend.push_back(tuning_word);
      if (tk) begin
         e = '{stamp: cyc + 1, acc: m_phase, act: m_play, rdy: (m_pend.size() == 0), is_rst: 1'b0};
         exp_q.push_back(e);
      end
   endtask

   // Drive one clock cycle of stimulus; the source holds its word until accepted.
   task automatic step(input bit rst, input bit on, input bit off, input bit gl);
      bit ok;
      if (have_reset) check("tw_ready", tw_ready, (m_pend.size() == 0));
      reset       = rst;
      note_on     = on;
      note_off    = off;
      glide_en    = gl;
      tw_valid    = !rst && (src_q.size() != 0);
      tuning_word = tw_valid ? src_q[0] : AW'($urandom);
      model_edge(ok);
      if (ok) void'(src_q.pop_front());
      @(negedge clk);
   endtask

   task automatic run(input int n, input bit gl);
      repeat (n) step(0, 0, 0, gl);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sample_tick === 1'b1 || reset === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("spurious_tick", sample_tick, 0);
            end else begin
               e = exp_q.pop_front();
               check("tick_cycle", cyc, e.stamp);
               check("accumulator", accumulator, e.acc);
               check("active", active, e.act);
               check("tw_ready_at_tick", tw_ready, e.rdy);
               if (e.is_rst) check("sample_tick_in_reset", sample_tick, 0);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bit gl_r;
      int guard;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);

      // Steady increment, then half-scale wrap with retrigger.
      src_q.push_back(24'h010000); step(0, 1, 0, 0); run(SD * 5, 0);
      src_q.push_back(24'h800000); step(0, 1, 0, 0); run(SD * 5, 0);

      // Back-to-back words with valid held.
      src_q.push_back(24'h000100); src_q.push_back(24'h000300); run(SD * 5, 0);

      // Glide up then down.
      src_q.push_back(24'h001000); step(0, 1, 0, 0); run(SD * 3, 0);
      src_q.push_back(24'h002000); run(SD * 100, 1);
      src_q.push_back(24'h000800); run(SD * 60, 1);

      // Simultaneous on/off retriggers; off alone stops.
      step(0, 1, 1, 0); run(SD * 2, 0);
      step(0, 0, 1, 0); run(SD * 2, 0);

      // Random traffic.
      gl_r = 0;
      for (int i = 0; i < 400; i++) begin
         if (i % 60 == 0) gl_r = bit'($urandom_range(0, 1));
         if (src_q.size() == 0 && $urandom_range(0, 9) == 0)
            src_q.push_back(AW'($urandom_range(0, 32'h03FFFF)));
         step(0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0), gl_r);
      end

      // Reset mid-glide, with a word pending, on a tick cycle.
      src_q.push_back(24'h000100); step(0, 1, 0, 0); run(SD * 2, 0);
      src_q.push_back(24'h400000); run(SD * 3, 1);
      src_q.push_back(24'h123456);
      guard = 0;
      while (!(m_pend.size() != 0 && ((m_edge + 1) % SD == 0)) && guard < 4 * SD) begin
         step(0, 0, 0, 1);
         guard++;
      end
      check("reset_setup_reached", (guard < 4 * SD), 1);
      step(1, 0, 0, 1);
      run(SD * 3, 0);

      run(2, 0);
      check("pending_expectations", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
